vram_fill_sequencer: RTL and testbench
======================================

VRAM_FILL_SEQUENCER -- requirements
Module: vram_fill_sequencer

Interface
REQ-001 Parameter: COLOR_WIDTH, default 3, width of a VRAM pixel colour.
REQ-002 Parameter: COORD_WIDTH, default 8, width of a row or column coordinate; VRAM address width is 2*COORD_WIDTH.
REQ-003 Clock  in  1  single clock, rising edge.
REQ-004 Reset  in  1  synchronous, active-low reset.
REQ-005 iCpuWrite  in  1  CPU VGA-instruction pixel write request, one pixel per asserted cycle.
REQ-006 iCpuRow, iCpuCol  in  COORD_WIDTH each  CPU pixel coordinates.
REQ-007 iCpuColor  in  COLOR_WIDTH  CPU pixel colour.
REQ-008 iFillStart  in  1  single-cycle pulse; requests a rectangle fill.
REQ-009 iRow0, iCol0, iRow1, iCol1  in  COORD_WIDTH each  opposite rectangle corners, inclusive, any order.
REQ-010 iFillColor  in  COLOR_WIDTH  fill colour.
REQ-011 oFillBusy  out  1  high while a fill is in progress.
REQ-012 oFillDone  out  1  one-cycle pulse after the last fill pixel is issued.
REQ-013 oVramWe  out  1  VRAM write enable.
REQ-014 oVramAddress  out  2*COORD_WIDTH  {row, col}.
REQ-015 oVramData  out  COLOR_WIDTH  pixel colour.

Function
REQ-016 The FSM shall have three states: IDLE, FILL, DONE.
REQ-017 In IDLE, iFillStart shall latch corners and colour, normalise them (row_lo=min(iRow0,iRow1), row_hi=max; same for columns), set the cursor to (row_lo, col_lo), and go to FILL.
REQ-018 iFillStart in FILL or DONE shall be ignored, with no effect on the fill in progress.
REQ-019 In FILL, each cycle without iCpuWrite shall issue one fill write at the cursor, then advance it row-major: col+1, or, at col==col_hi, col=col_lo and row+1.
REQ-020 Limit detection shall use equality against col_hi/row_hi so that coordinate 255 does not wrap and cause an endless loop.
REQ-021 The fill write at (row_hi, col_hi) shall cause a transition to DONE; DONE shall assert oFillDone for exactly one cycle and then return to IDLE.
REQ-022 CPU writes shall have absolute priority: with iCpuWrite high, the CPU pixel is issued and the fill cursor holds that cycle, in any state.
REQ-023 oVramWe, oVramAddress and oVramData shall be registered with a latency of 1 cycle from the request cycle; with no write, oVramWe=0 and address/data hold their last values.
REQ-024 oFillBusy shall be 1 in FILL and 0 in IDLE and DONE.
REQ-025 A W x H rectangle with no CPU traffic shall complete in exactly W*H FILL cycles, each CPU-write cycle adding one.
REQ-026 A degenerate rectangle (row0==row1, col0==col1) shall write exactly one pixel.

Reset
REQ-027 With Reset low at a clock edge: state=IDLE and oVramWe=0, oFillBusy=0, oFillDone=0, oVramAddress=0, oVramData=0, cursor and latched corners 0.
REQ-028 Reset mid-fill shall abandon the fill immediately, with no oFillDone pulse and no further fill writes.

Configuration
REQ-029 With macro FILL_ABORT_EN defined, the block shall add input iFillAbort (1 bit); iFillAbort high in FILL returns to IDLE next cycle, issues no fill write that cycle and gives no oFillDone pulse; CPU writes are still honoured that cycle.
REQ-030 Without FILL_ABORT_EN, the iFillAbort port shall not exist and a fill always runs to completion.

Verification
REQ-031 Fill (0,0)-(1,2) colour 3'b100, idle CPU -> 6 writes at addresses 0x0000,0x0001,0x0002,0x0100,0x0101,0x0102; oFillDone one cycle after the last; oFillBusy high for 6 cycles.
REQ-032 Corners reversed (iRow0=1,iCol0=2,iRow1=0,iCol1=0) -> write sequence identical to REQ-031.
REQ-033 Fill (255,254)-(255,255) -> writes 0xFFFE, 0xFFFF, then DONE; no write to 0x0000 (no wrap).
REQ-034 During a 4-pixel fill, iCpuWrite on the 2nd FILL cycle with (5,5) colour 3'b010 -> the 2nd write is 0x0505/3'b010, fill completes in 5 cycles, and all 4 fill pixels are written once.
REQ-035 Reset low on the 3rd cycle of a 16-pixel fill -> oVramWe=0 and oFillBusy=0 next cycle; no oFillDone; a new iFillStart is accepted afterwards.
REQ-036 With FILL_ABORT_EN, iFillAbort on the 3rd FILL cycle of a 16-pixel fill -> exactly 2 fill writes; IDLE next cycle; no oFillDone.

Source files
------------

// File: rtl/vram_fill_sequencer.sv
// Rectangle fill sequencer for a {row,col}-addressed VRAM with CPU write priority.
// Optional FILL_ABORT_EN adds an iFillAbort input that cancels a running fill.
module vram_fill_sequencer #(
  parameter int COLOR_WIDTH = 3,
  parameter int COORD_WIDTH = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iCpuWrite,
  input  logic [COORD_WIDTH-1:0]   iCpuRow,
  input  logic [COORD_WIDTH-1:0]   iCpuCol,
  input  logic [COLOR_WIDTH-1:0]   iCpuColor,
  input  logic                     iFillStart,
  input  logic [COORD_WIDTH-1:0]   iRow0,
  input  logic [COORD_WIDTH-1:0]   iCol0,
  input  logic [COORD_WIDTH-1:0]   iRow1,
  input  logic [COORD_WIDTH-1:0]   iCol1,
  input  logic [COLOR_WIDTH-1:0]   iFillColor,
`ifdef FILL_ABORT_EN
  input  logic                     iFillAbort,
`endif
  output logic                     oFillBusy,
  output logic                     oFillDone,
  output logic                     oVramWe,
  output logic [2*COORD_WIDTH-1:0] oVramAddress,
  output logic [COLOR_WIDTH-1:0]   oVramData
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                 state, state_n;
  logic [COORD_WIDTH-1:0] row_lo, row_hi, col_lo, col_hi;
  logic [COORD_WIDTH-1:0] cur_row, cur_col;
  logic [COLOR_WIDTH-1:0] color;
  logic                   fill_we;
  logic                   abort;
  logic [COORD_WIDTH-1:0] n_row_lo, n_row_hi, n_col_lo, n_col_hi;

`ifdef FILL_ABORT_EN
  assign abort = iFillAbort;
`else
  assign abort = 1'b0;
`endif

  assign n_row_lo = (iRow0 < iRow1) ? iRow0 : iRow1;
  assign n_row_hi = (iRow0 < iRow1) ? iRow1 : iRow0;
  assign n_col_lo = (iCol0 < iCol1) ? iCol0 : iCol1;
  assign n_col_hi = (iCol0 < iCol1) ? iCol1 : iCol0;

  assign oFillBusy = (state == FILL);
  assign oFillDone = (state == DONE);

  always_comb begin
    state_n = state;
    fill_we = 1'b0;
    case (state)
      IDLE: if (iFillStart) state_n = FILL;
      FILL: begin
        if (abort) begin
          state_n = IDLE;
        end else if (!iCpuWrite) begin
          fill_we = 1'b1;
          // Equality on both limits keeps a 255 edge from wrapping to 0.
          if (cur_row == row_hi && cur_col == col_hi) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state        <= IDLE;
      row_lo       <= '0;
      row_hi       <= '0;
      col_lo       <= '0;
      col_hi       <= '0;
      cur_row      <= '0;
      cur_col      <= '0;
      color        <= '0;
      oVramWe      <= 1'b0;
      oVramAddress <= '0;
      oVramData    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && iFillStart) begin
        row_lo  <= n_row_lo;
        row_hi  <= n_row_hi;
        col_lo  <= n_col_lo;
        col_hi  <= n_col_hi;
        cur_row <= n_row_lo;
        cur_col <= n_col_lo;
        color   <= iFillColor;
      end else if (fill_we) begin
        if (cur_col == col_hi) begin
          cur_col <= col_lo;
          cur_row <= cur_row + 1'b1;
        end else begin
          cur_col <= cur_col + 1'b1;
        end
      end
      if (iCpuWrite) begin
        oVramWe      <= 1'b1;
        oVramAddress <= {iCpuRow, iCpuCol};
        oVramData    <= iCpuColor;
      end else if (fill_we) begin
        oVramWe      <= 1'b1;
        oVramAddress <= {cur_row, cur_col};
        oVramData    <= color;
      end else begin
        oVramWe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_fill_sequencer.sv
// Directed self-checking bench for vram_fill_sequencer; a negedge monitor logs
// VRAM writes, done pulses and busy cycles, and each test task checks them.
module tb_vram_fill_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iCpuWrite;
  logic [7:0]  iCpuRow, iCpuCol;
  logic [2:0]  iCpuColor;
  logic        iFillStart;
  logic [7:0]  iRow0, iCol0, iRow1, iCol1;
  logic [2:0]  iFillColor;
`ifdef FILL_ABORT_EN
  logic        iFillAbort;
`endif
  logic        oFillBusy, oFillDone, oVramWe;
  logic [15:0] oVramAddress;
  logic [2:0]  oVramData;

  int compared = 0;
  int mismatched = 0;

  vram_fill_sequencer #(.COLOR_WIDTH(3), .COORD_WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset),
    .iCpuWrite(iCpuWrite), .iCpuRow(iCpuRow), .iCpuCol(iCpuCol), .iCpuColor(iCpuColor),
    .iFillStart(iFillStart), .iRow0(iRow0), .iCol0(iCol0), .iRow1(iRow1), .iCol1(iCol1),
    .iFillColor(iFillColor),
`ifdef FILL_ABORT_EN
    .iFillAbort(iFillAbort),
`endif
    .oFillBusy(oFillBusy), .oFillDone(oFillDone), .oVramWe(oVramWe),
    .oVramAddress(oVramAddress), .oVramData(oVramData)
  );

  always #5 Clock = ~Clock;

  // Monitor: entries are {address, data}
  logic [18:0] wq[$];
  int cyc = 0, last_we_cyc = -1, done_cyc = -2, done_cnt = 0, busy_cnt = 0;

  always @(negedge Clock) begin
    cyc = cyc + 1;
    if (oVramWe === 1'b1) begin
      wq.push_back({oVramAddress, oVramData});
      last_we_cyc = cyc;
    end
    if (oFillDone === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (oFillBusy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic clear_mon();
    wq.delete();
    done_cnt = 0;
    busy_cnt = 0;
    last_we_cyc = -1;
    done_cyc = -2;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic start_fill(input logic [7:0] r0, c0, r1, c1, input logic [2:0] col);
    iRow0 = r0; iCol0 = c0; iRow1 = r1; iCol1 = c1; iFillColor = col;
    iFillStart = 1'b1;
    step(1);
    iFillStart = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    step(2);
    compared++; if (oVramWe !== 1'b0) begin mismatched++; $display("FAIL reset_we got %b want 0", oVramWe); end
    compared++; if (oVramAddress !== 16'h0000) begin mismatched++; $display("FAIL reset_addr got %h want 0000", oVramAddress); end
    compared++; if (oVramData !== 3'b000) begin mismatched++; $display("FAIL reset_data got %b want 000", oVramData); end
    compared++; if (oFillBusy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", oFillBusy); end
    compared++; if (oFillDone !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", oFillDone); end
    Reset = 1'b1;
    step(1);
  endtask

  task automatic test_fill_basic(input logic reversed);
    logic [18:0] exp [6];
    exp = '{{16'h0000, 3'b100}, {16'h0001, 3'b100}, {16'h0002, 3'b100},
            {16'h0100, 3'b100}, {16'h0101, 3'b100}, {16'h0102, 3'b100}};
    clear_mon();
    if (reversed) start_fill(8'd1, 8'd2, 8'd0, 8'd0, 3'b100);
    else          start_fill(8'd0, 8'd0, 8'd1, 8'd2, 3'b100);
    step(10);
    compared++; if (wq.size() != 6) begin mismatched++; $display("FAIL basic%0d_count got %0d want 6", reversed, wq.size()); end
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (i >= wq.size()) begin mismatched++; $display("FAIL basic%0d_w%0d got none want %h", reversed, i, exp[i]); end
      else if (wq[i] !== exp[i]) begin mismatched++; $display("FAIL basic%0d_w%0d got %h want %h", reversed, i, wq[i], exp[i]); end
    end
    compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL basic%0d_done_cnt got %0d want 1", reversed, done_cnt); end
    compared++; if (done_cyc != last_we_cyc) begin mismatched++; $display("FAIL basic%0d_done_timing got %0d want %0d", reversed, done_cyc, last_we_cyc); end
    compared++; if (busy_cnt != 6) begin mismatched++; $display("FAIL basic%0d_busy got %0d want 6", reversed, busy_cnt); end
  endtask

  task automatic test_edge_255();
    clear_mon();
    start_fill(8'd255, 8'd254, 8'd255, 8'd255, 3'b001);
    step(8);
    compared++; if (wq.size() != 2) begin mismatched++; $display("FAIL edge_count got %0d want 2", wq.size()); end
    compared++; if (wq.size() < 1 || wq[0] !== {16'hFFFE, 3'b001}) begin mismatched++; $display("FAIL edge_w0 got %h want %h", (wq.size() > 0) ? wq[0] : 19'h0, {16'hFFFE, 3'b001}); end
    compared++; if (wq.size() < 2 || wq[1] !== {16'hFFFF, 3'b001}) begin mismatched++; $display("FAIL edge_w1 got %h want %h", (wq.size() > 1) ? wq[1] : 19'h0, {16'hFFFF, 3'b001}); end
    compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL edge_done got %0d want 1", done_cnt); end
    compared++; if (oFillBusy !== 1'b0) begin mismatched++; $display("FAIL edge_busy_after got %b want 0", oFillBusy); end
  endtask

  task automatic test_cpu_priority();
    logic [18:0] exp [5];
    exp = '{{16'h0203, 3'b111}, {16'h0505, 3'b010}, {16'h0204, 3'b111},
            {16'h0303, 3'b111}, {16'h0304, 3'b111}};
    clear_mon();
    start_fill(8'd2, 8'd3, 8'd3, 8'd4, 3'b111);
    step(1);
    iCpuWrite = 1'b1; iCpuRow = 8'd5; iCpuCol = 8'd5; iCpuColor = 3'b010;
    step(1);
    iCpuWrite = 1'b0;
    step(8);
    compared++; if (wq.size() != 5) begin mismatched++; $display("FAIL cpu_count got %0d want 5", wq.size()); end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (i >= wq.size()) begin mismatched++; $display("FAIL cpu_w%0d got none want %h", i, exp[i]); end
      else if (wq[i] !== exp[i]) begin mismatched++; $display("FAIL cpu_w%0d got %h want %h", i, wq[i], exp[i]); end
    end
    compared++; if (busy_cnt != 5) begin mismatched++; $display("FAIL cpu_busy got %0d want 5", busy_cnt); end
    compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL cpu_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_cpu_idle();
    clear_mon();
    iCpuWrite = 1'b1; iCpuRow = 8'h12; iCpuCol = 8'h34; iCpuColor = 3'b101;
    step(1);
    iCpuWrite = 1'b0;
    compared++; if (oVramWe !== 1'b1 || oVramAddress !== 16'h1234 || oVramData !== 3'b101) begin
      mismatched++; $display("FAIL idle_cpu got we=%b %h/%b want we=1 1234/101", oVramWe, oVramAddress, oVramData); end
    step(1);
    compared++; if (oVramWe !== 1'b0 || oVramAddress !== 16'h1234 || oVramData !== 3'b101) begin
      mismatched++; $display("FAIL idle_hold got we=%b %h/%b want we=0 1234/101", oVramWe, oVramAddress, oVramData); end
    compared++; if (busy_cnt != 0) begin mismatched++; $display("FAIL idle_busy got %0d want 0", busy_cnt); end
  endtask

  task automatic test_start_ignored();
    clear_mon();
    start_fill(8'd1, 8'd1, 8'd1, 8'd2, 3'b011);
    iRow0 = 8'd9; iCol0 = 8'd9; iRow1 = 8'd9; iCol1 = 8'd9; iFillColor = 3'b110;
    iFillStart = 1'b1;
    step(1);
    iFillStart = 1'b0;
    step(6);
    compared++; if (wq.size() != 2) begin mismatched++; $display("FAIL ign_count got %0d want 2", wq.size()); end
    compared++; if (wq.size() < 2 || wq[0] !== {16'h0101, 3'b011} || wq[1] !== {16'h0102, 3'b011}) begin
      mismatched++; $display("FAIL ign_writes got %h,%h want %h,%h", (wq.size() > 0) ? wq[0] : 19'h0,
        (wq.size() > 1) ? wq[1] : 19'h0, {16'h0101, 3'b011}, {16'h0102, 3'b011}); end
    compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL ign_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    start_fill(8'd0, 8'd0, 8'd3, 8'd3, 3'b001);
    step(2);
    Reset = 1'b0;
    step(1);
    compared++; if (oVramWe !== 1'b0) begin mismatched++; $display("FAIL rst_mid_we got %b want 0", oVramWe); end
    compared++; if (oFillBusy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_busy got %b want 0", oFillBusy); end
    Reset = 1'b1;
    step(6);
    compared++; if (wq.size() != 2) begin mismatched++; $display("FAIL rst_mid_count got %0d want 2", wq.size()); end
    compared++; if (done_cnt != 0) begin mismatched++; $display("FAIL rst_mid_done got %0d want 0", done_cnt); end
    clear_mon();
    start_fill(8'd7, 8'd9, 8'd7, 8'd9, 3'b110);
    step(6);
    compared++; if (wq.size() != 1 || wq[0] !== {16'h0709, 3'b110}) begin
      mismatched++; $display("FAIL degen_write got n=%0d %h want n=1 %h", wq.size(), (wq.size() > 0) ? wq[0] : 19'h0, {16'h0709, 3'b110}); end
    compared++; if (done_cnt != 1 || busy_cnt != 1) begin
      mismatched++; $display("FAIL degen_done_busy got %0d/%0d want 1/1", done_cnt, busy_cnt); end
  endtask

`ifdef FILL_ABORT_EN
  task automatic test_abort();
    clear_mon();
    start_fill(8'd0, 8'd0, 8'd3, 8'd3, 3'b010);
    step(2);
    iFillAbort = 1'b1;
    step(1);
    iFillAbort = 1'b0;
    compared++; if (oFillBusy !== 1'b0) begin mismatched++; $display("FAIL abort_busy got %b want 0", oFillBusy); end
    step(6);
    compared++; if (wq.size() != 2) begin mismatched++; $display("FAIL abort_count got %0d want 2", wq.size()); end
    compared++; if (done_cnt != 0) begin mismatched++; $display("FAIL abort_done got %0d want 0", done_cnt); end
  endtask
`endif

  initial begin
    Reset = 1'b0; iCpuWrite = 1'b0; iCpuRow = '0; iCpuCol = '0; iCpuColor = '0;
    iFillStart = 1'b0; iRow0 = '0; iCol0 = '0; iRow1 = '0; iCol1 = '0; iFillColor = '0;
`ifdef FILL_ABORT_EN
    iFillAbort = 1'b0;
`endif
    test_reset();
    test_fill_basic(1'b0);
    test_fill_basic(1'b1);
    test_edge_255();
    test_cpu_priority();
    test_cpu_idle();
    test_start_ignored();
    test_reset_mid();
`ifdef FILL_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
